// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register.
// Default field widths, a saturating Tnew decrement helper, and the
// default-width slot record seen by hazard/forwarding logic.
package pipe_pkg;

    localparam int unsigned PAYLOAD_W_DEF = 96;
    localparam int unsigned TNEW_W_DEF    = 2;
    localparam int unsigned RA_W_DEF      = 5;

    // Widest Tnew field the helper handles; callers widen/narrow around it.
    localparam int unsigned TNEW_W_MAX    = 8;

    typedef logic [TNEW_W_MAX-1:0] tnew_max_t;

    // Saturating decrement: 0 stays 0, anything else counts down by one.
    function automatic tnew_max_t sat_dec(input tnew_max_t x);
        return (x == '0) ? '0 : x - TNEW_W_MAX'(1);
    endfunction

    // One stage slot at default widths.
    typedef struct packed {
        logic                     valid;
        logic [PAYLOAD_W_DEF-1:0] payload;
        logic [TNEW_W_DEF-1:0]    tnew;
        logic                     regwrite;
        logic [RA_W_DEF-1:0]      regwa;
    } slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One entry register of the stage (used for both the main and skid slot).
// Ports:
//   clk, reset          rising-edge clock, async active-low reset
//   load, clear         load the ld_* fields / empty the slot (clear wins)
//   ld_*                field values to store on load (already conditioned)
//   valid, payload, tnew, regwrite, regwa   stored entry; zeros when empty
// A held valid entry counts its Tnew down each clock when HOLD_DEC != 0.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W = PAYLOAD_W_DEF,
    parameter int unsigned TNEW_W    = TNEW_W_DEF,
    parameter int unsigned RA_W      = RA_W_DEF,
    parameter int unsigned HOLD_DEC  = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] ld_payload,
    input  logic [TNEW_W-1:0]    ld_tnew,
    input  logic                 ld_regwrite,
    input  logic [RA_W-1:0]      ld_regwa,
    output logic                 valid,
    output logic [PAYLOAD_W-1:0] payload,
    output logic [TNEW_W-1:0]    tnew,
    output logic                 regwrite,
    output logic [RA_W-1:0]      regwa
);

    // Entry storage: clear produces an all-zero bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid    <= 1'b0;
            payload  <= '0;
            tnew     <= '0;
            regwrite <= 1'b0;
            regwa    <= '0;
        end else if (clear) begin
            valid    <= 1'b0;
            payload  <= '0;
            tnew     <= '0;
            regwrite <= 1'b0;
            regwa    <= '0;
        end else if (load) begin
            valid    <= 1'b1;
            payload  <= ld_payload;
            tnew     <= ld_tnew;
            regwrite <= ld_regwrite;
            regwa    <= ld_regwa;
        end else if (valid && (HOLD_DEC != 0)) begin
            tnew     <= TNEW_W'(sat_dec(tnew_max_t'(tnew)));
        end
    end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with one skid slot.
// Main slot M drives out_*; skid slot S catches the one entry upstream may
// send after a downstream stall, so in_ready never depends combinationally
// on out_ready. Tnew counts down per clock, flush squashes both slots.
// Ports:
//   clk, reset                      clock, async active-low reset
//   flush                           synchronous squash of M and S
//   in_valid/in_ready/in_*          upstream handshake and entry fields
//   out_valid/out_ready/out_*       downstream handshake and M fields
//   skid_*                          S fields for the hazard unit
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int unsigned PAYLOAD_W     = PAYLOAD_W_DEF,
    parameter int unsigned TNEW_W        = TNEW_W_DEF,
    parameter int unsigned RA_W          = RA_W_DEF,
    parameter int unsigned TNEW_HOLD_DEC = 1
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [TNEW_W-1:0]    in_tnew,
    input  logic                 in_regwrite,
    input  logic [RA_W-1:0]      in_regwa,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [TNEW_W-1:0]    out_tnew,
    output logic                 out_regwrite,
    output logic [RA_W-1:0]      out_regwa,
    output logic                 skid_valid,
    output logic [TNEW_W-1:0]    skid_tnew,
    output logic                 skid_regwrite,
    output logic [RA_W-1:0]      skid_regwa
);

    logic                 in_fire_c;
    logic                 out_fire_c;
    logic [TNEW_W-1:0]    in_tnew_dec_c;
    logic                 in_regwrite_c;
    logic [TNEW_W-1:0]    s_tnew_mv_c;
    logic [PAYLOAD_W-1:0] s_payload;

    logic                 m_load_c;
    logic                 m_clear_c;
    logic                 m_from_s_c;
    logic                 s_load_c;
    logic                 s_clear_c;
    logic                 in_ready_nxt_c;

    logic [PAYLOAD_W-1:0] m_ld_payload_c;
    logic [TNEW_W-1:0]    m_ld_tnew_c;
    logic                 m_ld_regwrite_c;
    logic [RA_W-1:0]      m_ld_regwa_c;

    // Handshakes and input conditioning ($0 is never a real write target).
    always_comb begin
        in_fire_c     = in_valid & in_ready;
        out_fire_c    = out_valid & out_ready;
        in_tnew_dec_c = TNEW_W'(sat_dec(tnew_max_t'(in_tnew)));
        in_regwrite_c = in_regwrite & (in_regwa != '0);
        s_tnew_mv_c   = (TNEW_HOLD_DEC != 0) ? TNEW_W'(sat_dec(tnew_max_t'(skid_tnew)))
                                             : skid_tnew;
    end

    // Slot control: flush first, then refill M (from S before input), else spill to S.
    always_comb begin
        m_load_c   = 1'b0;
        m_clear_c  = 1'b0;
        m_from_s_c = 1'b0;
        s_load_c   = 1'b0;
        s_clear_c  = 1'b0;
        if (flush) begin
            m_clear_c = 1'b1;
            s_clear_c = 1'b1;
        end else if (!out_valid || out_fire_c) begin
            if (skid_valid) begin
                m_load_c   = 1'b1;
                m_from_s_c = 1'b1;
                s_clear_c  = 1'b1;
            end else if (in_fire_c) begin
                m_load_c   = 1'b1;
            end else begin
                m_clear_c  = 1'b1;
            end
        end else if (in_fire_c) begin
            s_load_c = 1'b1;
        end
    end

    // M load source select.
    always_comb begin
        m_ld_payload_c  = in_payload;
        m_ld_tnew_c     = in_tnew_dec_c;
        m_ld_regwrite_c = in_regwrite_c;
        m_ld_regwa_c    = in_regwa;
        if (m_from_s_c) begin
            m_ld_payload_c  = s_payload;
            m_ld_tnew_c     = s_tnew_mv_c;
            m_ld_regwrite_c = skid_regwrite;
            m_ld_regwa_c    = skid_regwa;
        end
    end

    // Ready tracks next-cycle S occupancy.
    always_comb begin
        in_ready_nxt_c = ~skid_valid;
        if (s_load_c) begin
            in_ready_nxt_c = 1'b0;
        end else if (s_clear_c) begin
            in_ready_nxt_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_ready <= 1'b1;
        end else begin
            in_ready <= in_ready_nxt_c;
        end
    end

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .TNEW_W    (TNEW_W),
        .RA_W      (RA_W),
        .HOLD_DEC  (TNEW_HOLD_DEC)
    ) u_m_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (m_load_c),
        .clear       (m_clear_c),
        .ld_payload  (m_ld_payload_c),
        .ld_tnew     (m_ld_tnew_c),
        .ld_regwrite (m_ld_regwrite_c),
        .ld_regwa    (m_ld_regwa_c),
        .valid       (out_valid),
        .payload     (out_payload),
        .tnew        (out_tnew),
        .regwrite    (out_regwrite),
        .regwa       (out_regwa)
    );

    pipe_slot #(
        .PAYLOAD_W (PAYLOAD_W),
        .TNEW_W    (TNEW_W),
        .RA_W      (RA_W),
        .HOLD_DEC  (TNEW_HOLD_DEC)
    ) u_s_slot (
        .clk         (clk),
        .reset       (reset),
        .load        (s_load_c),
        .clear       (s_clear_c),
        .ld_payload  (in_payload),
        .ld_tnew     (in_tnew_dec_c),
        .ld_regwrite (in_regwrite_c),
        .ld_regwa    (in_regwa),
        .valid       (skid_valid),
        .payload     (s_payload),
        .tnew        (skid_tnew),
        .regwrite    (skid_regwrite),
        .regwa       (skid_regwa)
    );

endmodule
